core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It fetches instruction words, holds the instruction register that feeds the combinational instruction decoder, and sequences execute, memory and writeback. It also computes the next PC and traps on illegal opcodes or misaligned control-flow targets. It sits between the instruction/data memory ports and the decoder/ALU/register-file datapath.

---
 rtl/core_sequencer.sv | 152 +++++++++++++++
 tb/tb_core_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with next-PC logic.
// Optional feature: define SEQ_INSTRET_EN to build the 64-bit retired-instruction counter.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic [31:0]        ir,
  output logic [31:0]        pc,
  input  logic [6:0]         opcode,
  input  logic signed [31:0] imm,
  input  logic [31:0]        alu_result,
  input  logic               branch_taken,
  output logic               rf_we,
  output logic               retire,
  output logic               halt,
  output logic [2:0]         state,
  output logic [63:0]        instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  state_t      st_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] pc_seq;
  logic [31:0] pc_rel;
  logic [31:0] npc;
  logic        legal;
  logic        is_mem;
  logic        is_store;
  logic        misalign;

  assign pc_seq   = pc_q + 32'd4;
  assign pc_rel   = pc_q + imm;
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;
  assign misalign = (npc[1:0] != 2'b00);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  always_comb begin
    npc = pc_seq;
    case (opcode)
      OP_JAL:    npc = pc_rel;
      OP_JALR:   npc = alu_result & ~32'd1;
      OP_BRANCH: npc = branch_taken ? pc_rel : pc_seq;
      default:   npc = pc_seq;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= NOP;
    end else begin
      case (st_q)
        FETCH: begin
          if (imem_ack) begin
            ir_q <= imem_rdata;
            st_q <= DECODE;
          end
        end
        DECODE: st_q <= legal ? EXEC : TRAP;
        EXEC:   st_q <= is_mem ? MEM : WB;
        MEM: begin
          if (dmem_ack) begin
            if (is_store) begin
              pc_q <= pc_seq;
              st_q <= FETCH;
            end else begin
              st_q <= WB;
            end
          end
        end
        WB: begin
          // A misaligned target traps with pc still pointing at the faulting instruction.
          if (misalign) begin
            st_q <= TRAP;
          end else begin
            pc_q <= npc;
            st_q <= FETCH;
          end
        end
        TRAP:    st_q <= TRAP;
        default: st_q <= TRAP;
      endcase
    end
  end

  // Requests decode straight from state so an async reset withdraws them immediately.
  assign imem_req  = rst_n && (st_q == FETCH);
  assign imem_addr = pc_q;
  assign dmem_req  = (st_q == MEM);
  assign dmem_we   = (st_q == MEM) && is_store;
  assign rf_we     = (st_q == WB) && !misalign && (opcode != OP_BRANCH);
  assign retire    = ((st_q == WB) && !misalign) || ((st_q == MEM) && dmem_ack && is_store);
  assign halt      = (st_q == TRAP);
  assign state     = st_q;
  assign ir        = ir_q;
  assign pc        = pc_q;

`ifdef SEQ_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed and randomized instruction streams
// compared against a per-instruction latency/next-PC reference model.
module tb_core_sequencer;

  localparam logic [31:0] RST_PC   = 32'h0000_0100;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_ALUI   = 7'h13;
  localparam logic [6:0] OP_ALU    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        rf_we;
  logic        retire;
  logic        halt;
  logic [2:0]  state;
  logic [63:0] instret;
  logic [5:0]  ctl;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mpc;
  logic [63:0] mret;
  logic [6:0]  ops [9];

  always #5 clk = ~clk;

  // Decoder stand-in: opcode is the low seven bits of the latched instruction.
  assign opcode = ir[6:0];
  assign ctl    = {imem_req, dmem_req, dmem_we, rf_we, retire, halt};

  core_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .ir           (ir),
    .pc           (pc),
    .opcode       (opcode),
    .imm          (imm),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .rf_we        (rf_we),
    .retire       (retire),
    .halt         (halt),
    .state        (state),
    .instret      (instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef SEQ_INSTRET_EN
    return mret;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op);
    logic [31:0] w;
    w = $urandom;
    w[6:0] = op;
    return w;
  endfunction

  // One clock cycle: entered just after a negedge with inputs already set.
  task automatic cyc(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, ctl, exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", ctl, 6'b000000);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_state", state, 3'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = RST_PC;
    mret = 64'd0;
  endtask

  // Reference for one instruction: FETCH (iw waits), DECODE, EXEC, MEM (dw waits), WB.
  task automatic exec_instr(input string tag, input logic [31:0] word, input logic [31:0] iv,
                            input logic [31:0] av, input logic bt, input int iw, input int dw);
    logic [6:0]  op;
    logic [31:0] tgt;
    logic        legal, mem, st, bad;
    op = word[6:0];
    legal = op inside {OP_LOAD, OP_STORE, OP_ALUI, OP_ALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH};
    mem = (op == OP_LOAD) || (op == OP_STORE);
    st = (op == OP_STORE);
    imm = iv;
    alu_result = av;
    branch_taken = bt;
    if (op == OP_JAL) tgt = mpc + iv;
    else if (op == OP_JALR) tgt = av & ~32'd1;
    else if (op == OP_BRANCH && bt) tgt = mpc + iv;
    else tgt = mpc + 32'd4;
    bad = (tgt[1:0] != 2'b00);

    for (int i = 0; i <= iw; i++) begin
      imem_ack = (i == iw);
      imem_rdata = (i == iw) ? word : $urandom;
      #1;
      chk({tag, ":addr"}, imem_addr, mpc);
      chk({tag, ":fetch"}, ctl, 6'b100000);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk({tag, ":ir"}, ir, word);
    cyc({tag, ":decode"}, 6'b000000);
    if (!legal) begin
      cyc({tag, ":trap"}, 6'b000001);
    end else begin
      cyc({tag, ":exec"}, 6'b000000);
      if (mem) begin
        for (int j = 0; j <= dw; j++) begin
          dmem_ack = (j == dw);
          cyc({tag, ":mem"}, {1'b0, 1'b1, st, 1'b0, st && (j == dw), 1'b0});
        end
        dmem_ack = 1'b0;
      end
      if (st) begin
        mpc = mpc + 32'd4;
        mret = mret + 64'd1;
      end else if (bad) begin
        cyc({tag, ":wb_bad"}, 6'b000000);
        cyc({tag, ":trap"}, 6'b000001);
      end else begin
        cyc({tag, ":wb"}, {3'b000, op != OP_BRANCH, 1'b1, 1'b0});
        mpc = tgt;
        mret = mret + 64'd1;
      end
    end
    #1;
    chk({tag, ":pc"}, pc, mpc);
    chk({tag, ":instret"}, instret, exp_instret());
    @(negedge clk);
    // The extra negedge is an idle FETCH cycle (no ack) that the model treats as a wait.
  endtask

  task automatic hold_halt(input string tag);
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      imem_rdata = $urandom;
      cyc({tag, ":halt"}, 6'b000001);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk({tag, ":state"}, state, 3'd7);
    chk({tag, ":pc"}, pc, mpc);
    chk({tag, ":instret"}, instret, exp_instret());
  endtask

  initial begin
    logic [6:0] op;
    ops = '{OP_LOAD, OP_STORE, OP_ALUI, OP_ALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH};
    rst_n = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    dmem_ack = 1'b0;
    imm = 32'd0;
    alu_result = 32'd0;
    branch_taken = 1'b0;
    #2;
    do_reset();

    exec_instr("addi", mk(OP_ALUI), 32'd5, 32'd0, 1'b0, 0, 0);
    chk("addi_pc104", pc, 32'h104);

    exec_instr("jal200", mk(OP_JAL), 32'h200 - mpc, 32'd0, 1'b0, 1, 0);
    exec_instr("load", mk(OP_LOAD), 32'd8, 32'h300, 1'b0, 0, 3);
    chk("load_pc204", pc, 32'h204);

    exec_instr("jal40a", mk(OP_JAL), 32'h40 - mpc, 32'd0, 1'b0, 0, 0);
    exec_instr("br_t", mk(OP_BRANCH), 32'hFFFF_FFF8, 32'd0, 1'b1, 0, 0);
    chk("br_t_pc38", pc, 32'h38);
    exec_instr("jal40b", mk(OP_JAL), 32'h40 - mpc, 32'd0, 1'b0, 2, 0);
    exec_instr("br_nt", mk(OP_BRANCH), 32'hFFFF_FFF8, 32'd0, 1'b0, 0, 0);
    chk("br_nt_pc44", pc, 32'h44);

    for (int n = 0; n < 30; n++) begin
      op = ops[$urandom_range(0, 8)];
      exec_instr("rand", mk(op), ($urandom & 32'h0000_0FFC) - 32'h0000_0800,
                 $urandom & 32'hFFFF_FFFD, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    exec_instr("jal_top", mk(OP_JAL), 32'hFFFF_FFFC - mpc, 32'd0, 1'b0, 0, 0);
    exec_instr("wrap", mk(OP_ALU), 32'd0, 32'd0, 1'b0, 0, 0);
    chk("wrap_pc0", pc, 32'h0);

    exec_instr("jalr_bad", mk(OP_JALR), 32'd0, 32'h0000_1003, 1'b0, 0, 0);
    hold_halt("jalr_bad");

    do_reset();
    exec_instr("illegal", 32'h0000_0000, 32'd0, 32'd0, 1'b0, 0, 0);
    hold_halt("illegal");

    do_reset();
    exec_instr("pre_st", mk(OP_ALUI), 32'd1, 32'd0, 1'b0, 0, 0);
    imem_ack = 1'b1;
    imem_rdata = mk(OP_STORE);
    cyc("st_fetch", 6'b100000);
    imem_ack = 1'b0;
    cyc("st_decode", 6'b000000);
    cyc("st_exec", 6'b000000);
    cyc("st_mem_wait", 6'b011000);
    #1;
    chk("st_mem_held", ctl, 6'b011000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("st_rst_dmem_req", dmem_req, 1'b0);
    chk("st_rst_pc", pc, RST_PC);
    chk("st_rst_state", state, 3'd0);
    chk("st_rst_instret", instret, 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
